// File: rtl/uart_tx_if.sv
// Byte-request / serial-line bundle between a byte source and the UART transmitter.
// The master requests frames; the slave (transmitter) drives the line and status.
interface uart_tx_if;
  logic       trmt;
  logic [7:0] tx_data;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  modport master (output trmt, tx_data, input tx, tx_busy, tx_done);
  modport slave  (input trmt, tx_data, output tx, tx_busy, tx_done);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one 10-bit frame (start 0, 8 data LSB-first, stop 1) per accepted
// request, each bit held BAUD_DIV clocks. Line, busy and done are all registered.
module uart_tx #(
  parameter int unsigned BAUD_DIV = 2605   // legal 2..4095; matches uart_rx bit period
) (
  input  logic clk,
  input  logic rst_n,
  uart_tx_if.slave bus
);

  typedef enum logic {IDLE, TX} state_t;

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);

  state_t      state;
  logic [9:0]  shft;
  logic [11:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic        busy_q;
  logic        done_q;

  // The line is the low bit of the shift register, so it can never glitch.
  assign bus.tx      = shft[0];
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

  // NOTE: non-blocking assignments throughout so every register sees pre-edge values;
  // the async reset branch forces the line idle-high at once, even mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shft     <= '1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.trmt) begin
            shft     <= {1'b1, bus.tx_data, 1'b0};
            baud_cnt <= '0;
            bit_cnt  <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            state    <= TX;
          end
        end
        TX: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            shft     <= {1'b1, shft[9:1]};
            if (bit_cnt == 4'd9) begin
              // End of stop bit; shifting in ones leaves shft all ones for IDLE.
              bit_cnt <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 12'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter serialising one byte per request as a 10-bit frame (start 0, 8 data LSB-first, stop 1) on a single line at a fixed baud divisor. It is the transmit-side counterpart of `uart_rx` and uses the same bit period (2605 clocks, 12'hA2D), so a direct `tx`→`rx` connection loops back cleanly. It sits between the SNN result logic (byte source) and the board serial pin.

## Interface
- BAUD_DIV, 2605: clocks per bit period; legal range 2..4095; baud counter is 12 bits.
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- trmt  input  1  transmit request; sampled only in IDLE.
- tx_data  input  8  byte to send; captured on the accepting edge, ignored otherwise.
- tx  output  1  serial line; idle high; registered (glitch-free).
- tx_busy  output  1  high while a frame is in flight.
- tx_done  output  1  sticky: set when a frame's stop bit finishes, cleared when the next request is accepted or on reset.

## Operation
- Datapath: 10-bit shift register `shft`, 12-bit baud counter `baud_cnt`, 4-bit bit counter `bit_cnt`. `tx` = `shft[0]`.
- States: IDLE, TX.
- IDLE: `tx_busy`=0, `shft` all ones. If `trmt`=1 at a rising edge: load `shft` = {1'b1, tx_data, 1'b0}, `baud_cnt`=0, `bit_cnt`=0, clear `tx_done`, go TX.
- TX: `tx_busy`=1; `baud_cnt` increments each clock. When `baud_cnt`=BAUD_DIV-1: `baud_cnt`←0, `shft`←{1'b1, shft[9:1]}, `bit_cnt`←`bit_cnt`+1.
- Shift occurring with `bit_cnt`=9 (end of stop bit): go IDLE, set `tx_done`, `tx` stays 1.
- `trmt` while in TX ignored entirely (no queueing); `tx_data` changes during TX have no effect on the frame.
- Reset asserted at any time, including mid-frame: state IDLE, `tx`=1, `tx_busy`=0, `tx_done`=0, counters 0, `shft` all ones, immediately (asynchronous). A truncated frame is not resumed.

## Timing
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0.
- Accept edge E: `tx` falls to 0 and `tx_busy` rises at edge E (visible in the cycle after E).
- Each bit (start, d0..d7, stop) held exactly BAUD_DIV clocks; bit k occupies edges E+k·BAUD_DIV to E+(k+1)·BAUD_DIV.
- At edge E+10·BAUD_DIV: `tx_busy`→0, `tx_done`→1, state IDLE. Total frame = 10·BAUD_DIV clocks.
- `trmt` high at the completion edge itself is ignored (state still TX); earliest next accept is E+10·BAUD_DIV+1. Hence `trmt` held continuously gives back-to-back frames with stop bit lasting BAUD_DIV+1 clocks.
- `trmt` and reset simultaneous: reset wins.
- `tx_done` and `tx_busy` are never both 1.

## Test plan
- Reset then idle 3000 clocks -> `tx`=1, `tx_busy`=0, `tx_done`=0 throughout.
- `trmt` 1-clock pulse with 8'hA5, sample `tx` at mid-bit (offset BAUD_DIV/2) -> sequence 0,1,0,1,0,0,1,0,1,1; `tx_done` rises exactly 10·2605=26050 clocks after accept edge, `tx_busy` low same edge.
- Loopback `tx`→`uart_rx.rx`, send 8'hE7, 8'h24, 8'h01, 8'h00, 8'hFF -> each `rx_rdy` pulse presents matching `rx_data`; no `rx_rdy` before stop bit.
- Pulse `trmt` with 8'h3C, then re-pulse `trmt` with 8'hC3 at bits 2 and 9 -> only 8'h3C frame transmitted; `tx` idle high after; `tx_done`=1.
- Hold `trmt`=1 with 8'h55 for two frames -> two complete frames, second start bit falls 26051 clocks after first; `tx_done` clears on the second accept edge.
- Assert `rst_n`=0 mid data bit 4 of 8'h0F -> `tx`=1, `tx_busy`=0, `tx_done`=0 without waiting for a clock edge; after release, new 8'h81 frame is correct on loopback.
